// File: rtl/spi_pkg.sv
// Shared register map, bit positions and engine state encoding for spi_master.
// No logic; constants and types only.
// No flow control.
package spi_pkg;

    // Register offsets, decoded from paddr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_CS     = 2'd3;

    // STATUS bit indices
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_BUSY     = 4;
    localparam int ST_RX_OVF   = 5;

    // CTRL field positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_DIV_LSB  = 8;
    localparam int CTRL_DIV_MSB  = 15;

    // CS register bit
    localparam int CS_BIT = 0;

    // Shift engine states
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCK_LO,
        SCK_HI,
        DONE
    } spi_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy count.
// Read data is combinational from the head entry; push/pop commit on the clock edge.
// Push when full and pop when empty are ignored; fullness is judged at the start of the cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries behind the write pointer are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/spi_master.sv
// APB-attached mode-0 SPI master with TX/RX byte FIFOs, software chip select and level irq.
// APB is zero-wait; a byte takes 2 + 16*(CLKDIV+1) cycles from LOAD to DONE inclusive.
// Full TX rejects writes with perr; empty RX read returns 0 with perr; full RX drops bytes and flags overflow.
module spi_master
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  APB_PRESETn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    output logic                  irq,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_cs_n
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    spi_state_t state, state_nxt;

    logic            acc, wr_acc, rd_acc;
    logic [1:0]      reg_sel;
    logic            ctrl_en, ctrl_irq_en;
    logic [7:0]      clkdiv;
    logic            cs_q;
    logic            rx_ovf;
    logic [7:0]      div_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      tx_sr;
    logic [7:0]      rx_sr;
    logic            phase_end;
    logic            busy;
    logic [DATA_WIDTH-1:0] rdata;

    logic            tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]      tx_dat;
    logic [CW-1:0]   tx_cnt;
    logic            rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]      rx_dat;
    logic [CW-1:0]   rx_cnt;
    logic            unused_ok;

    assign acc     = psel & penable;
    assign wr_acc  = acc & pwrite;
    assign rd_acc  = acc & ~pwrite;
    assign reg_sel = paddr[3:2];
    assign pready  = acc;

    assign tx_push = wr_acc & (reg_sel == REG_DATA) & pstb[0];
    assign rx_pop  = rd_acc & (reg_sel == REG_DATA);

    assign phase_end = (div_cnt >= clkdiv);
    assign busy      = (state != IDLE);
    assign spi_cs_n  = cs_q;
    assign irq       = ctrl_irq_en & ((tx_empty & ~busy) | ~rx_empty | rx_ovf);

    assign unused_ok = ^{1'b0, paddr[ADDR_WIDTH-1:4], paddr[1:0],
                         pdata[DATA_WIDTH-1:16], pstb[3:2], tx_cnt, rx_cnt};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst_n    (APB_PRESETn),
        .push     (tx_push),
        .push_dat (pdata[7:0]),
        .pop      (tx_pop),
        .pop_dat  (tx_dat),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_cnt)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .rst_n    (APB_PRESETn),
        .push     (rx_push),
        .push_dat (rx_sr),
        .pop      (rx_pop),
        .pop_dat  (rx_dat),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (rx_cnt)
    );

    // Software-visible control: CTRL, CS and the sticky overflow flag
    always_ff @(posedge clk or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            clkdiv      <= 8'h00;
            cs_q        <= 1'b1;
            rx_ovf      <= 1'b0;
        end else begin
            if (wr_acc && reg_sel == REG_CTRL) begin
                if (pstb[0]) begin
                    ctrl_en     <= pdata[CTRL_EN];
                    ctrl_irq_en <= pdata[CTRL_IRQ_EN];
                end
                if (pstb[1]) clkdiv <= pdata[CTRL_DIV_MSB:CTRL_DIV_LSB];
            end
            if (wr_acc && reg_sel == REG_CS && pstb[0]) cs_q <= pdata[CS_BIT];
            // A new overflow wins over a clear landing in the same cycle
            if (rx_push && rx_full)
                rx_ovf <= 1'b1;
            else if (wr_acc && reg_sel == REG_STATUS && pstb[0] && pdata[ST_RX_OVF])
                rx_ovf <= 1'b0;
        end
    end

    // Read mux; all unused bits read as zero
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_DATA:   rdata[7:0] = rx_empty ? 8'h00 : rx_dat;
            REG_STATUS: begin
                rdata[ST_TX_FULL]  = tx_full;
                rdata[ST_TX_EMPTY] = tx_empty;
                rdata[ST_RX_FULL]  = rx_full;
                rdata[ST_RX_EMPTY] = rx_empty;
                rdata[ST_BUSY]     = busy;
                rdata[ST_RX_OVF]   = rx_ovf;
            end
            REG_CTRL: begin
                rdata[CTRL_EN]                   = ctrl_en;
                rdata[CTRL_IRQ_EN]               = ctrl_irq_en;
                rdata[CTRL_DIV_MSB:CTRL_DIV_LSB] = clkdiv;
            end
            default:    rdata[CS_BIT] = cs_q;
        endcase
    end

    assign prdata = rd_acc ? rdata : '0;
    assign perr   = acc & (reg_sel == REG_DATA) & (pwrite ? (pstb[0] & tx_full) : rx_empty);

    // Engine state register
    always_ff @(posedge clk or negedge APB_PRESETn) begin
        if (!APB_PRESETn) state <= IDLE;
        else              state <= state_nxt;
    end

    // Engine next state; enable is only consulted between bytes
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctrl_en && !tx_empty) state_nxt = LOAD;
            LOAD:    state_nxt = SCK_LO;
            SCK_LO:  if (phase_end) state_nxt = SCK_HI;
            SCK_HI:  if (phase_end) state_nxt = (bit_cnt == 3'd0) ? DONE : SCK_LO;
            DONE:    state_nxt = (ctrl_en && !tx_empty) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Engine outputs decoded from state; MOSI shows the head byte's MSB during LOAD
    always_comb begin
        spi_sck  = 1'b0;
        spi_mosi = tx_sr[7];
        tx_pop   = 1'b0;
        rx_push  = 1'b0;
        case (state)
            IDLE:    spi_mosi = 1'b0;
            LOAD:    begin tx_pop = 1'b1; spi_mosi = tx_dat[7]; end
            SCK_HI:  spi_sck = 1'b1;
            DONE:    rx_push = 1'b1;
            default: ;
        endcase
    end

    // Divider, bit counter and shifters; MISO sampled on the first SCK-high cycle
    always_ff @(posedge clk or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            div_cnt <= 8'h00;
            bit_cnt <= 3'd0;
            tx_sr   <= 8'h00;
            rx_sr   <= 8'h00;
        end else begin
            if ((state == SCK_LO || state == SCK_HI) && !phase_end)
                div_cnt <= div_cnt + 1'b1;
            else
                div_cnt <= 8'h00;
            case (state)
                LOAD: begin
                    tx_sr   <= tx_dat;
                    bit_cnt <= 3'd7;
                end
                SCK_HI: begin
                    if (div_cnt == 8'h00) rx_sr <= {rx_sr[6:0], spi_miso};
                    if (phase_end) begin
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
# spi_master

APB slave peripheral providing a mode-0 SPI master with 4-deep TX and RX byte FIFOs, software-controlled chip select and a level interrupt. It sits on the SoC APB bus beside the UART and timer, is decoded by the APB interconnect through its own select/enable pair, and feeds its `irq` into a spare input of the interrupt controller.

## Interface
- `ADDR_WIDTH`, 32, APB address width
- `DATA_WIDTH`, 32, APB data width
- `FIFO_DEPTH`, 4, TX/RX FIFO depth in bytes, power of two ≥2
- `clk`  in  1  single system clock, all logic on rising edge
- `APB_PRESETn`  in  1  reset; one clock; reset is asynchronous and active-low
- `paddr`  in  ADDR_WIDTH  byte address; only `paddr[3:2]` decoded
- `pdata`  in  DATA_WIDTH  write data
- `prdata`  out  DATA_WIDTH  read data
- `psel`  in  1  slave select from interconnect
- `penable`  in  1  access phase
- `pwrite`  in  1  1 = write
- `pstb`  in  4  byte strobes
- `pready`  out  1  transfer complete
- `perr`  out  1  slave error
- `irq`  out  1  level interrupt to interrupt controller
- `spi_sck`  out  1  serial clock, idles low
- `spi_mosi`  out  1  serial data out, MSB first
- `spi_miso`  in  1  serial data in, used without synchronizer
- `spi_cs_n`  out  1  chip select, software driven

## Operation
- Registers (`paddr[3:2]`):
  - 0 DATA: write with `pstb[0]` pushes `pdata[7:0]` to TX; read pops RX and returns the byte in `[7:0]`
  - 1 STATUS (RO except bit 5): 0 tx_full, 1 tx_empty, 2 rx_full, 3 rx_empty, 4 busy, 5 rx_overflow (write 1 to clear)
  - 2 CTRL: 0 enable, 1 irq_en, `[15:8]` CLKDIV; reset 0
  - 3 CS: bit 0 drives `spi_cs_n` directly; reset 1
- Unwritten bytes (`pstb` bit clear) keep old values. Reads of unused bits return 0.
- `perr` is 1 on a DATA write with TX full (byte dropped) and on a DATA read with RX empty (returns 0, no pop). It is 0 otherwise.
- Engine FSM:
  - IDLE → LOAD when enable=1 and TX not empty.
  - LOAD (1 cycle): pop TX, load shifter, `spi_mosi`=bit7.
  - SCK_LO: hold CLKDIV+1 cycles → SCK_HI.
  - SCK_HI: sample `spi_miso` into the shifter on the first cycle; hold CLKDIV+1 cycles.
  - After bit 0, go to DONE; otherwise shift, drive the next MOSI bit and return to SCK_LO.
  - DONE (1 cycle): push the RX byte, or set rx_overflow and drop it if RX is full. Then go to LOAD if enable and TX not empty, else IDLE.
- busy = state ≠ IDLE.
- `irq` = irq_en & ((tx_empty & !busy) | !rx_empty | rx_overflow).
- Clearing enable mid-byte: the current byte completes and no new LOAD starts.

## Timing
- `pready` = `psel & penable`, combinational. Every access is zero-wait.
- `prdata` and `perr` are valid in the access phase and are 0 whenever `psel & penable` is 0.
- Register and FIFO side effects commit on the `clk` edge ending the access phase.
- Byte duration: LOAD→DONE inclusive = 2 + 16·(CLKDIV+1) cycles.
- First SCK rise is CLKDIV+2 cycles after LOAD. Back-to-back bytes add no IDLE cycle.
- FIFO counts are width log2(FIFO_DEPTH)+1 and pointers wrap modulo FIFO_DEPTH.
- Simultaneous APB push and engine pop on TX: both happen and the count is unchanged. Same rule on RX (engine push, APB pop).
- A push to a FIFO that is full at the start of the cycle is rejected even if a pop happens in that same cycle.
- Reset values: `spi_sck` 0, `spi_mosi` 0, `spi_cs_n` 1, `irq` 0, `pready`/`perr`/`prdata` 0, FSM IDLE, FIFOs empty, CTRL 0, rx_overflow 0.
- Reset asserted mid-byte aborts the transfer at once. Outputs take reset values asynchronously.

## Structure
- Package `spi_pkg`: register offset constants, STATUS bit indices, CTRL field positions, FSM state enum (IDLE, LOAD, SCK_LO, SCK_HI, DONE).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count; async active-low reset), instantiated twice.
- Top level holds the APB decode, CTRL/CS registers, divider counter, bit counter, shifter and FSM.

## Test plan
- Reset, then read all four registers → CTRL=0, CS=1, STATUS=0x0A, `spi_sck`=0, `spi_cs_n`=1.
- CLKDIV=1, enable, write 0xA5, loop MOSI to MISO → MOSI bits 1,0,1,0,0,1,0,1 on SCK rises; busy for 34 cycles; RX read returns 0xA5.
- Write 5 bytes while enable=0 → fifth write gives `perr`=1 and tx_full=1; after enable, exactly 4 bytes are shifted.
- Shift 5 bytes without reading RX → rx_overflow=1; irq=1 with irq_en; write STATUS bit5=1 clears it; the first 4 bytes are read back intact.
- Read DATA with RX empty → `prdata`=0, `perr`=1. Push during engine pop with TX count 4→ write rejected (`perr`=1); count 3 → accepted, count stays 3.
- Assert `APB_PRESETn` low mid-byte (SCK high) → `spi_sck`=0 and `spi_cs_n`=1 immediately; FIFOs empty after release.
